// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: byte FIFO between UART receiver and transmitter in the echo path
//   clk, reset_n (async, active-low)
//   rx_char/rx_dataready/rx_framing in, rx_readdata out: receiver handshake, one-cycle ack
//   tx_char/tx_sendchar out, tx_busy in: transmitter handshake, one-cycle strobe
//   count/empty/full: occupancy; frame_errs: saturating count of dropped framing-error bytes
//   `define FIFO_UPCASE_EN to present a..z as A..Z on tx_char
module uart_echo_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_char,
  input  logic          rx_dataready,
  input  logic          rx_framing,
  output logic          rx_readdata,
  output logic [7:0]    tx_char,
  output logic          tx_sendchar,
  input  logic          tx_busy,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic [7:0]    frame_errs
);
  typedef enum logic [1:0] {IDLE, SEND, GUARD} state_e;
  state_e        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q, rx_readdata_q, tx_sendchar_q;
  logic [7:0]    tx_char_q, frame_errs_q, rd_byte;
  logic          acc, wr_en, pop_en;
  always_comb begin
    acc     = rx_dataready && !rx_readdata_q && (rx_framing || !full_q);
    wr_en   = acc && !rx_framing;
    pop_en  = (state_q == IDLE) && !empty_q && !tx_busy;
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop_en);
  end
`ifdef FIFO_UPCASE_EN
  always_comb rd_byte = (mem_q[rd_ptr_q] >= 8'h61 && mem_q[rd_ptr_q] <= 8'h7A) ? (mem_q[rd_ptr_q] & 8'hDF) : mem_q[rd_ptr_q];
`else
  always_comb rd_byte = mem_q[rd_ptr_q];
`endif
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_ptr_q] <= rx_char;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      rx_readdata_q <= 1'b0;
      tx_sendchar_q <= 1'b0;
      tx_char_q     <= 8'h00;
      frame_errs_q  <= 8'h00;
    end else begin
      rx_readdata_q <= acc;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (acc && rx_framing && frame_errs_q != 8'hFF) frame_errs_q <= frame_errs_q + 8'd1;
      count_q <= count_d;
      empty_q <= count_d == '0;
      full_q  <= count_d == (AW+1)'(DEPTH);
      case (state_q)
        IDLE: if (pop_en) begin
          tx_char_q     <= rd_byte;
          rd_ptr_q      <= rd_ptr_q + AW'(1);
          tx_sendchar_q <= 1'b1;
          state_q       <= SEND;
        end
        SEND: begin
          tx_sendchar_q <= 1'b0;
          state_q       <= GUARD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx_readdata = rx_readdata_q;
  assign tx_char     = tx_char_q;
  assign tx_sendchar = tx_sendchar_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign frame_errs  = frame_errs_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: scoreboard bench for uart_echo_fifo
module tb_uart_echo_fifo;
  logic       clk, reset_n;
  logic [7:0] rx_char;
  logic       rx_dataready, rx_framing, rx_readdata;
  logic [7:0] tx_char;
  logic       tx_sendchar, tx_busy;
  logic [4:0] count;
  logic       empty, full;
  logic [7:0] frame_errs;
  int         checks = 0, errors = 0, strobes = 0, max_cnt = 0, s0;
  logic [7:0] exp_q[$];
  logic       prev_rd = 1'b0;
  logic       found;
  uart_echo_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .rx_char(rx_char), .rx_dataready(rx_dataready),
    .rx_framing(rx_framing), .rx_readdata(rx_readdata), .tx_char(tx_char),
    .tx_sendchar(tx_sendchar), .tx_busy(tx_busy), .count(count), .empty(empty),
    .full(full), .frame_errs(frame_errs)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (int'(count) > max_cnt) max_cnt = int'(count);
    check("empty_flag", empty, count == 5'd0);
    check("full_flag", full, count == 5'd16);
    check("ack_spacing", rx_readdata & prev_rd, 0);
    prev_rd = rx_readdata;
    if (tx_sendchar) begin
      strobes++;
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_char", tx_char, exp_q.pop_front());
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic f, input int gap, input logic [7:0] e);
    logic ok;
    rx_char = b;
    rx_framing = f;
    rx_dataready = 1'b1;
    if (!f) exp_q.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_readdata) begin
        ok = 1'b1;
        break;
      end
    end
    rx_dataready = 1'b0;
    rx_framing = 1'b0;
    check("ack_seen", ok, 1);
    repeat (gap) @(negedge clk);
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("drain_count", count, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [7:0] up_in [4];
    logic [7:0] up_ex [4];
    up_in = '{8'h61, 8'h7A, 8'h7B, 8'h41};
`ifdef FIFO_UPCASE_EN
    up_ex = '{8'h41, 8'h5A, 8'h7B, 8'h41};
`else
    up_ex = '{8'h61, 8'h7A, 8'h7B, 8'h41};
`endif
    reset_n = 1'b1; rx_char = 8'h00; rx_dataready = 1'b0; rx_framing = 1'b0; tx_busy = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_readdata", rx_readdata, 0);
    check("rst_sendchar", tx_sendchar, 0);
    check("rst_tx_char", tx_char, 8'h00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_frame_errs", frame_errs, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    // single byte latency
    rx_char = 8'h41; rx_dataready = 1'b1; exp_q.push_back(8'h41);
    @(negedge clk);
    check("t1_ack", rx_readdata, 1);
    check("t1_count1", count, 1);
    rx_dataready = 1'b0;
    @(negedge clk);
    check("t1_strobe", tx_sendchar, 1);
    check("t1_tx_char", tx_char, 8'h41);
    check("t1_count0", count, 0);
    drain(20);
    // fill to full with busy transmitter, 17th byte held
    tx_busy = 1'b1;
    fork
      for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0, 0, 8'(i));
    join_none
    for (int i = 0; i < 300 && count != 5'd16; i++) @(negedge clk);
    check("t2_count16", count, 16);
    @(negedge clk);
    check("t2_full", full, 1);
    for (int i = 0; i < 5; i++) check("t2_held", rx_readdata, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_held_cycle", rx_readdata, 0);
    end
    check("t2_count_held", count, 16);
    tx_busy = 1'b0;
    drain(400);
    wait fork;
    // framing-error bytes are consumed, counted, never stored
    send_byte(8'h55, 1'b1, 0, 8'h00);
    @(negedge clk);
    check("t3_count", count, 0);
    check("t3_frame1", frame_errs, 1);
    for (int i = 0; i < 299; i++) send_byte(8'h55, 1'b1, 0, 8'h00);
    @(negedge clk);
    check("t3_frame_sat", frame_errs, 255);
    check("t3_count_end", count, 0);
    // streaming across pointer wrap
    max_cnt = 0;
    for (int i = 0; i < 40; i++) send_byte(8'hA0 + 8'(i), 1'b0, 2, 8'hA0 + 8'(i));
    drain(100);
    check("t4_max_count_le2", max_cnt <= 2, 1);
    // reset while in SEND with 5 queued
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b0, 0, 8'h30 + 8'(i));
    check("t5_count6", count, 6);
    tx_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_sendchar) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_strobe_found", found, 1);
    check("t5_count5", count, 5);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_sendchar", tx_sendchar, 0);
    check("t5_rst_readdata", rx_readdata, 0);
    check("t5_rst_tx_char", tx_char, 8'h00);
    check("t5_rst_count", count, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_full", full, 0);
    check("t5_rst_frame_errs", frame_errs, 0);
    exp_q.delete();
    s0 = strobes;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_strobe", strobes - s0, 0);
    send_byte(8'h42, 1'b0, 0, 8'h42);
    drain(20);
    check("t5_one_strobe", strobes - s0, 1);
    // upper-case option
    for (int i = 0; i < 4; i++) send_byte(up_in[i], 1'b0, 0, up_ex[i]);
    drain(50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Byte FIFO between the UART receiver and the UART transmitter in the echo path.
- Takes bytes from the receiver through its char/dataready/readdata handshake and buffers up to DEPTH of them.
- Drains them to the transmitter through its data/sendchar/busy handshake, so back-to-back received characters are not lost while the transmitter is busy.
- Drops bytes flagged with a framing error and counts them.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock (12 MHz board clock)
- reset_n  in  1  asynchronous, active-low reset
- rx_char  in  8  received byte from the receiver
- rx_dataready  in  1  receiver holds a byte; level, stays high until acknowledged
- rx_framing  in  1  framing error flag for the byte on rx_char; qualified by rx_dataready
- rx_readdata  out  1  one-cycle acknowledge to the receiver; receiver releases the byte
- tx_char  out  8  byte presented to the transmitter
- tx_sendchar  out  1  one-cycle send strobe to the transmitter
- tx_busy  in  1  transmitter busy
- count  out  AW+1  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- frame_errs  out  8  number of dropped framing-error bytes; saturates at 255

Behaviour:
Reset (async, reset_n low): rx_readdata=0, tx_sendchar=0, tx_char=8'h00, count=0, empty=1, full=0, frame_errs=0, wr/rd pointers=0, drain FSM=IDLE. Storage contents are not reset.

Write side (registered acknowledge):
- Accept condition in a cycle: rx_dataready=1, rx_readdata=0, and not blocked by full.
- Accept with rx_framing=0 and full=0: write rx_char at wr_ptr, increment wr_ptr mod DEPTH, set rx_readdata<=1 for the next cycle.
- Accept with rx_framing=1: ack the same way (the byte is consumed) but do not write; frame_errs increments unless already 255. A framing byte is accepted even when full.
- rx_framing=0 and full=1: no ack, no write. The byte stays held in the receiver (backpressure); it is written on the first cycle full drops.
- rx_readdata is never high two cycles in a row. At most one accept per 2 cycles.

Drain FSM (states IDLE, SEND, GUARD):
- IDLE: if empty=0 and tx_busy=0, then tx_char<=mem[rd_ptr], rd_ptr++ mod DEPTH, tx_sendchar<=1, go to SEND. Otherwise stay.
- SEND: tx_sendchar<=0, go to GUARD.
- GUARD: go to IDLE unconditionally. This state gives the transmitter one cycle to raise busy before IDLE samples it.
- tx_sendchar is high exactly one cycle per popped byte. tx_char holds its value until the next pop.
- Minimum spacing between strobes is 3 cycles, and is further gated by tx_busy.

Occupancy:
- count updates on the same edge as the write/pop.
- Write and pop on the same edge leave count unchanged and perform both pointer updates.
- empty and full are registered and consistent with count every cycle.
- Pointer wrap at DEPTH-1 → 0 is seamless.
- A pop is never issued from empty; a write is never issued to full. There is no overwrite.
- Deasserting reset_n mid-transfer discards all queued bytes. The first post-reset strobe occurs only after a new byte is written.

Optional Feature:
- Macro: FIFO_UPCASE_EN.
- Defined: on pop, bytes 8'h61..8'h7A are presented on tx_char with bit 5 cleared (a-z → A-Z); all other bytes pass unchanged. Storage, count and frame_errs are unaffected.
- Undefined: tx_char is the stored byte unmodified.

Test Plan:
- Single byte 8'h41, tx_busy=0 → rx_readdata pulses 1 cycle after accept; 1 cycle later tx_sendchar pulses with tx_char=8'h41; count goes 0→1→0.
- tx_busy held 1; write 17 bytes 8'h00..8'h10 (DEPTH=16) → 16 acked, full=1, count=16, 17th not acked and held. Release tx_busy → 8'h00..8'h0F emitted in order, 8'h10 acked after the first pop and emitted last.
- Byte 8'h55 with rx_framing=1 → acked, count stays 0, no strobe, frame_errs=1. 300 such bytes → frame_errs=255.
- Continuous writes and pops across pointer wrap (40 bytes, tx_busy=0) → output sequence equals input, count never exceeds 2.
- reset_n low while count=5 and the FSM is in SEND → all outputs at reset values immediately. After release, no tx_sendchar until a new byte arrives.
- With FIFO_UPCASE_EN: input 8'h61, 8'h7A, 8'h7B, 8'h41 → tx_char 8'h41, 8'h5A, 8'h7B, 8'h41.
